// File: rtl/adder_scheduler_pkg.sv
// Shared types and sizing for the sign-magnitude adder scheduler.
// The requester count is fixed at four so a 2-bit index always suffices.
package adder_scheduler_pkg;

    localparam int NREQ      = 4;
    localparam int IDX_W     = 2;
    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_scheduler_arb.sv
// Stateless four-way round-robin grant: search starts at ptr and wraps 3->0.
// Produces a one-hot gnt, or all zeros when nothing is requested.
module rr_arbiter4
    import adder_scheduler_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // 2-bit addition wraps the search back to requester 0
            idx = ptr + 2'(i);
            if (req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_scheduler.sv
// Arbitrates four requesters onto one sign-magnitude adder; one operation
// is in flight at a time (grant -> execute -> response handshake).
module adder_scheduler
    import adder_scheduler_pkg::*;
#(
    parameter int bitNUmber = DEFAULT_W
) (
    input  logic                      clk1,
    input  logic                      rst1,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*bitNUmber-1:0] req_a,
    input  logic [NREQ*bitNUmber-1:0] req_b,
    output logic                      rsp_valid,
    output logic [IDX_W-1:0]          rsp_id,
    output logic [bitNUmber-1:0]      rsp_sum,
    output logic                      rsp_carry,
    input  logic                      rsp_ready
);

    localparam int MW = bitNUmber - 1;

    state_t                 state_reg;
    logic [IDX_W-1:0]       ptr_reg;
    logic [bitNUmber-1:0]   a_reg;
    logic [bitNUmber-1:0]   b_reg;
    logic [IDX_W-1:0]       id_reg;
    logic                   rsp_valid_reg;
    logic [IDX_W-1:0]       rsp_id_reg;
    logic [bitNUmber-1:0]   rsp_sum_reg;
    logic                   rsp_carry_reg;

    logic [NREQ-1:0]        gnt;
    logic [bitNUmber-1:0]   a_slice [NREQ];
    logic [bitNUmber-1:0]   b_slice [NREQ];
    logic [bitNUmber-1:0]   sel_a;
    logic [bitNUmber-1:0]   sel_b;
    logic [IDX_W-1:0]       gnt_idx;
    logic [bitNUmber:0]     add_res;

    // Returns {carry, sign, magnitude}
    function automatic logic [bitNUmber:0] sm_add(
        input logic [bitNUmber-1:0] a,
        input logic [bitNUmber-1:0] b
    );
        logic [MW-1:0] ma;
        logic [MW-1:0] mb;
        logic [MW-1:0] mag;
        logic [MW:0]   full;
        logic          sign;
        logic          carry;
        ma    = a[MW-1:0];
        mb    = b[MW-1:0];
        full  = {1'b0, ma} + {1'b0, mb};
        mag   = full[MW-1:0];
        carry = full[MW];
        sign  = a[MW];
        if (a[MW] != b[MW]) begin
            carry = 1'b0;
            if (ma >= mb) begin
                mag  = ma - mb;
                sign = a[MW];
            end else begin
                mag  = mb - ma;
                sign = b[MW];
            end
        end
        // A zero result is always reported as +0
        if (mag == '0 && !carry) begin
            sign = 1'b0;
        end
        return {carry, sign, mag};
    endfunction

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*bitNUmber +: bitNUmber];
            assign b_slice[gi] = req_b[gi*bitNUmber +: bitNUmber];
        end
    endgenerate

    rr_arbiter4 u_arb (
        .req (req_valid),
        .ptr (ptr_reg),
        .gnt (gnt)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a   = a_slice[i];
                sel_b   = b_slice[i];
                gnt_idx = IDX_W'(i);
            end
        end
    end

    assign add_res   = sm_add(a_reg, b_reg);
    assign req_ready = (state_reg == IDLE && !rst1) ? gnt : '0;

    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_sum_reg   <= '0;
            rsp_carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|gnt) begin
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        id_reg    <= gnt_idx;
                        ptr_reg   <= gnt_idx + 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_reg   <= add_res[bitNUmber-1:0];
                    rsp_carry_reg <= add_res[bitNUmber];
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_carry = rsp_carry_reg;

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler: arithmetic vectors, round-robin order,
// response back-pressure and reset during an in-flight operation.
module tb_adder_scheduler;

    logic        clk1;
    logic        rst1;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic        rsp_ready;

    int n_checks;
    int n_fail;

    adder_scheduler #(.bitNUmber(8)) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ready (rsp_ready)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on negedge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk1);
    endtask

    task automatic apply_reset();
        next_cycle();
        rst1      = 1'b1;
        req_valid = 4'hF;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        next_cycle();
        req_valid = 4'h0;
        rst1      = 1'b0;
        #1;
    endtask

    // Single-requester transaction with immediate response acceptance.
    task automatic run_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum, input logic exp_carry);
        string t;
        t = $sformatf("txn%0d_%02h_%02h", id, a, b);
        next_cycle();
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid        = 4'b0001 << id;
        rsp_ready        = 1'b1;
        #1;
        check_eq({t, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        next_cycle();
        req_valid = 4'h0;
        #1;
        check_eq({t, "_exec_valid"}, 32'(rsp_valid), 32'h0);
        next_cycle();
        #1;
        check_eq({t, "_valid"}, 32'(rsp_valid), 32'h1);
        check_eq({t, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check_eq({t, "_carry"}, 32'(rsp_carry), 32'(exp_carry));
        check_eq({t, "_id"}, 32'(rsp_id), 32'(id));
        $display("txn id=%0d a=%02h b=%02h -> sum=%02h carry=%0d", id, a, b, rsp_sum, rsp_carry);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst1      = 1'b1;
        req_valid = 4'h0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        apply_reset();
        check_eq("rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_sum", 32'(rsp_sum), 32'h0);
        check_eq("rst_carry", 32'(rsp_carry), 32'h0);
        check_eq("rst_id", 32'(rsp_id), 32'h0);
        check_eq("idle_no_req", 32'(req_ready), 32'h0);

        // Arithmetic vectors
        run_txn(0, 8'h05, 8'h03, 8'h08, 1'b0);
        run_txn(1, 8'h05, 8'h83, 8'h02, 1'b0);
        run_txn(2, 8'h03, 8'h85, 8'h82, 1'b0);
        run_txn(3, 8'h05, 8'h85, 8'h00, 1'b0);
        run_txn(0, 8'h7F, 8'h01, 8'h00, 1'b1);
        run_txn(1, 8'hFF, 8'h81, 8'h80, 1'b1);
        run_txn(2, 8'h83, 8'h83, 8'h86, 1'b0);

        // Round-robin with all requesters pending: requester i adds (i+1)+0x10
        apply_reset();
        req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
        req_b     = {8'h10, 8'h10, 8'h10, 8'h10};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            int exp_id;
            exp_id = k % 4;
            check_eq($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(4'b0001 << exp_id));
            next_cycle();
            #1;
            check_eq($sformatf("rr%0d_exec_ready", k), 32'(req_ready), 32'h0);
            next_cycle();
            #1;
            check_eq($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(exp_id));
            check_eq($sformatf("rr%0d_sum", k), 32'(rsp_sum), 32'(8'h11 + exp_id));
            check_eq($sformatf("rr%0d_resp_ready", k), 32'(req_ready), 32'h0);
            $display("rr grant=%0d rsp_id=%0d sum=%02h", k, rsp_id, rsp_sum);
            next_cycle();
            #1;
        end

        // Back-pressure: requester 2 granted, response held for 5 cycles
        apply_reset();
        rsp_ready    = 1'b0;
        req_a[23:16] = 8'h86;
        req_b[23:16] = 8'h02;
        req_valid    = 4'b0100;
        #1;
        check_eq("bp_grant", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid    = 4'b0010;
        req_a[15:8]  = 8'h01;
        req_b[15:8]  = 8'h01;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("bp%0d_sum", k), 32'(rsp_sum), 32'h84);
            check_eq($sformatf("bp%0d_id", k), 32'(rsp_id), 32'h2);
            check_eq($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_hs_ready", 32'(req_ready), 32'h0);
        next_cycle();
        #1;
        check_eq("bp_after_valid", 32'(rsp_valid), 32'h0);
        check_eq("bp_after_grant", 32'(req_ready), 32'h2);
        $display("bp handshake done, next grant=%b", req_ready);
        next_cycle();
        next_cycle();
        #1;
        check_eq("bp_next_id", 32'(rsp_id), 32'h1);
        check_eq("bp_next_sum", 32'(rsp_sum), 32'h02);
        next_cycle();

        // Reset during EXEC: pointer is 2 here, all requesters pending
        req_valid = 4'hF;
        req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
        req_b     = {8'h20, 8'h20, 8'h20, 8'h20};
        #1;
        check_eq("rx_grant", 32'(req_ready), 32'h4);
        next_cycle();
        rst1 = 1'b1;
        next_cycle();
        rst1 = 1'b0;
        #1;
        check_eq("rx_valid0", 32'(rsp_valid), 32'h0);
        check_eq("rx_sum0", 32'(rsp_sum), 32'h0);
        check_eq("rx_regrant", 32'(req_ready), 32'h1);
        next_cycle();
        #1;
        check_eq("rx_valid1", 32'(rsp_valid), 32'h0);
        next_cycle();
        #1;
        check_eq("rx_valid2", 32'(rsp_valid), 32'h1);
        check_eq("rx_id", 32'(rsp_id), 32'h0);
        check_eq("rx_sum", 32'(rsp_sum), 32'h21);
        $display("reset-in-exec: first response id=%0d sum=%02h", rsp_id, rsp_sum);
        req_valid = 4'h0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
